// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit adder between NREQ
// valid/ready requesters. The result is held in a single registered
// response slot, tagged with the requester ID and the carry-out. A
// saturating counter tracks accepted results that carried.
module adder_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic [CNT_W-1:0]         carry_count,
  output logic                     busy
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [WIDTH-1:0]       sum_q, sum_d;
  logic                   carry_q, carry_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   accept;
  logic                   found;
  logic                   grant;
  logic [ID_W-1:0]        gnt_idx;
  logic [WIDTH-1:0]       a_sel, b_sel;
  logic [WIDTH:0]         sum_full;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Wrap-around search for the first valid requester at or after the pointer.
  always_comb begin
    logic [ID_W:0] pos;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (pos >= (ID_W+1)'(NREQ)) pos = pos - (ID_W+1)'(NREQ);
      if (!found && req_valid[pos[ID_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = pos[ID_W-1:0];
      end
    end
  end

  // Operand mux for the granted requester feeding the shared adder.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == gnt_idx) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_full  = {1'b0, a_sel} + {1'b0, b_sel};
  assign accept    = (state_q == EMPTY) || rsp_ready;
  assign grant     = accept && found && !rst;
  assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;

  // Next-state: slot fill/drain, pointer rotation and carry counting.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if ((state_q == FULL) && rsp_ready && carry_q) cnt_d = sat_inc(cnt_q);
    if (grant) begin
      state_d = FULL;
      id_d    = gnt_idx;
      sum_d   = sum_full[WIDTH-1:0];
      carry_d = sum_full[WIDTH];
      ptr_d   = (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + ID_W'(1);
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // State register with synchronous reset that also clears the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid   = (state_q == FULL);
  assign busy        = (state_q == FULL);
  assign rsp_id      = id_q;
  assign rsp_sum     = sum_q;
  assign rsp_carry   = carry_q;
  assign carry_count = cnt_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the slot,
// pointer and counters. A second instance with a 2-bit counter exercises
// counter saturation on the same stimulus.
module tb_adder_rr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  rsp_ready;

  logic [NREQ-1:0] req_ready, req_ready_s;
  logic            rsp_valid, rsp_valid_s;
  logic [ID_W-1:0] rsp_id, rsp_id_s;
  logic [WIDTH-1:0] rsp_sum, rsp_sum_s;
  logic            rsp_carry, rsp_carry_s;
  logic [7:0]      carry_count;
  logic [1:0]      carry_count_s;
  logic            busy, busy_s;

  adder_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .carry_count(carry_count), .busy(busy));

  adder_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready_s), .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id_s), .rsp_sum(rsp_sum_s), .rsp_carry(rsp_carry_s),
    .carry_count(carry_count_s), .busy(busy_s));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int m_ptr, m_id, m_sum, m_carry, m_cnt8, m_cnt2;
  bit m_valid;
  int last_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (rst) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input int a, input int b);
    req_valid[i] = v;
    req_a[i*WIDTH +: WIDTH] = a[WIDTH-1:0];
    req_b[i*WIDTH +: WIDTH] = b[WIDTH-1:0];
  endtask

  // One clock: check grant before the edge, advance the model, check outputs after.
  task automatic step();
    int g, a, b, s;
    logic [31:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = (g < 0) ? 32'd0 : (32'd1 << g);
    chk("req_ready", 32'(req_ready), exp_rdy);
    chk("req_ready_s", 32'(req_ready_s), exp_rdy);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_ptr = 0; m_id = 0; m_sum = 0; m_carry = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (m_valid && rsp_ready && m_carry == 1) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (g >= 0) begin
        a = int'(req_a[g*WIDTH +: WIDTH]);
        b = int'(req_b[g*WIDTH +: WIDTH]);
        s = a + b;
        m_sum   = s % (1 << WIDTH);
        m_carry = s / (1 << WIDTH);
        m_id    = g;
        m_valid = 1;
        m_ptr   = (g + 1) % NREQ;
      end else if (m_valid && rsp_ready) begin
        m_valid = 0;
      end
    end
    last_gnt = g;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_valid));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
    chk("rsp_carry", 32'(rsp_carry), 32'(m_carry));
    chk("carry_count", 32'(carry_count), 32'(m_cnt8));
    chk("carry_count_s", 32'(carry_count_s), 32'(m_cnt2));
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] held_sum;
  logic [ID_W-1:0]  held_id;

  initial begin
    rst = 1'b1; rsp_ready = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    m_valid = 0; m_ptr = 0; m_id = 0; m_sum = 0; m_carry = 0; m_cnt8 = 0; m_cnt2 = 0;
    last_gnt = -1;
    step();
    step();
    rst = 1'b0;
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_count", 32'(carry_count), 32'd0);

    // Single request: 4+4
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 4, 4);
    #1 chk("t1_grant", 32'(req_ready), 32'b0001);
    step();
    clear_reqs();
    chk("t1_sum", 32'(rsp_sum), 32'd8);
    chk("t1_id", 32'(rsp_id), 32'd0);
    step();

    // Carry wrap: 15+4, then 1+3
    set_req(2, 1'b1, 15, 4);
    step();
    clear_reqs();
    chk("t2_sum", 32'(rsp_sum), 32'd3);
    chk("t2_carry", 32'(rsp_carry), 32'd1);
    chk("t2_id", 32'(rsp_id), 32'd2);
    step();
    chk("t2_count", 32'(carry_count), 32'd1);
    set_req(1, 1'b1, 1, 3);
    step();
    clear_reqs();
    chk("t2b_sum", 32'(rsp_sum), 32'd4);
    chk("t2b_carry", 32'(rsp_carry), 32'd0);
    step();

    // Fairness: all four valid continuously from pointer 0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i, i + 1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t3_id", 32'(rsp_id), 32'(k % NREQ));
      set_req(last_gnt, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15));
    end

    // Backpressure: only req1 and req3 valid, slot held for 5 cycles
    clear_reqs();
    set_req(1, 1'b1, 7, 2);
    set_req(3, 1'b1, 9, 9);
    rsp_ready = 1'b0;
    held_sum = rsp_sum;
    held_id  = rsp_id;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_hold_sum", 32'(rsp_sum), 32'(held_sum));
      chk("t4_hold_id", 32'(rsp_id), 32'(held_id));
    end
    rsp_ready = 1'b1;
    step();
    chk("t4_next_id", 32'(rsp_id), 32'd3);
    chk("t4_next_sum", 32'(rsp_sum), 32'd2);
    clear_reqs();
    step();

    // Reset mid-operation with pointer at 2
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 15, 15);
    step();
    step();
    do_reset();
    chk("t5_valid", 32'(rsp_valid), 32'd0);
    chk("t5_count", 32'(carry_count), 32'd0);
    step();
    chk("t5_id", 32'(rsp_id), 32'd0);

    // Saturation of the 2-bit counter with back-to-back 8+8
    do_reset();
    clear_reqs();
    set_req(0, 1'b1, 8, 8);
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t6_sat", 32'(carry_count_s), 32'((k < 3) ? k : 3));
    end
    clear_reqs();
    step();
    step();

    // Randomized traffic obeying the hold-until-ready rule
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (last_gnt == i || !req_valid[i])
          set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
